// File: rtl/dds_key_ctrl.sv
// -----------------------------------------------------------------------------
// dds_key_ctrl
// Converts debounced key pulses into DDS configuration: a waveform selector and
// a 32-bit phase increment. Each accepted key causes exactly one UPDATE cycle
// with a cfg_valid strobe. This is followed by a fixed lockout. Pulses that
// arrive outside IDLE are discarded.
// -----------------------------------------------------------------------------
module dds_key_ctrl #(
  parameter logic [31:0] FW_INIT  = 32'd85_899,
  parameter logic [31:0] FW_STEP  = 32'd85_899,
  parameter logic [31:0] FW_MIN   = 32'd85_899,
  parameter logic [31:0] FW_MAX   = 32'd858_993_459,
  parameter logic [15:0] LOCK_CNT = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_wave,
  input  logic        key_up,
  input  logic        key_dn,
  output logic [1:0]  wave_sel,
  output logic [31:0] freq_word,
  output logic        cfg_valid,
  output logic        at_limit
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_WAVE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DN   = 2'd2
  } cmd_t;

  // at_limit value that matches freq_word = FW_INIT
  localparam logic RST_LIMIT = (FW_INIT == FW_MIN) || (FW_INIT == FW_MAX);

  state_t      r_state;
  cmd_t        r_cmd;
  logic [15:0] r_lock_cnt;
  logic [1:0]  r_wave_sel;
  logic [31:0] r_freq_word;
  logic        r_cfg_valid;
  logic        r_at_limit;

  // Saturation compares use 33 bits, so a value near 2^32 cannot wrap past a bound
  logic [32:0] w_sum;
  logic [32:0] w_floor;
  logic [31:0] w_freq_up;
  logic [31:0] w_freq_dn;
  logic [31:0] w_freq_next;
  logic [1:0]  w_wave_next;
  logic        w_limit_next;

  assign w_sum     = {1'b0, r_freq_word} + {1'b0, FW_STEP};
  assign w_floor   = {1'b0, FW_MIN} + {1'b0, FW_STEP};
  assign w_freq_up = (w_sum > {1'b0, FW_MAX}) ? FW_MAX : (r_freq_word + FW_STEP);
  assign w_freq_dn = ({1'b0, r_freq_word} < w_floor) ? FW_MIN : (r_freq_word - FW_STEP);

  // Output values that the latched command will produce in the UPDATE cycle
  always_comb begin
    // NOTE: every output of a combinational block gets a default first.
    // Otherwise a path that does not assign it infers a latch.
    w_freq_next = r_freq_word;
    w_wave_next = r_wave_sel;
    case (r_cmd)
      CMD_WAVE: w_wave_next = r_wave_sel + 2'd1;
      CMD_UP:   w_freq_next = w_freq_up;
      CMD_DN:   w_freq_next = w_freq_dn;
      default:  ;
    endcase
    w_limit_next = (w_freq_next == FW_MIN) || (w_freq_next == FW_MAX);
  end

  // Control FSM: accept a key in IDLE, apply it in UPDATE, then count out LOCK
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= CMD_WAVE;
      r_lock_cnt  <= 16'd0;
      r_wave_sel  <= 2'd0;
      r_freq_word <= FW_INIT;
      r_cfg_valid <= 1'b0;
      r_at_limit  <= RST_LIMIT;
    end else begin
      // NOTE: registered state uses non-blocking assignment. Every branch then
      // sees the values from before the clock edge, so statement order does not
      // matter and simulation matches the synthesised flops.
      case (r_state)
        S_IDLE: begin
          r_cfg_valid <= 1'b0;
          if (key_wave) begin
            r_cmd   <= CMD_WAVE;
            r_state <= S_UPDATE;
          end else if (key_up) begin
            r_cmd   <= CMD_UP;
            r_state <= S_UPDATE;
          end else if (key_dn) begin
            r_cmd   <= CMD_DN;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_wave_sel  <= w_wave_next;
          r_freq_word <= w_freq_next;
          r_at_limit  <= w_limit_next;
          r_cfg_valid <= 1'b1;
          r_lock_cnt  <= 16'd0;
          r_state     <= S_LOCK;
        end
        S_LOCK: begin
          r_cfg_valid <= 1'b0;
          if (r_lock_cnt == LOCK_CNT) begin
            r_lock_cnt <= 16'd0;
            r_state    <= S_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 16'd1;
          end
        end
        default: begin
          r_cfg_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign wave_sel  = r_wave_sel;
  assign freq_word = r_freq_word;
  assign cfg_valid = r_cfg_valid;
  assign at_limit  = r_at_limit;

endmodule
